pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter N, default 32: width of every PC-valued port and register.
REQ-002 Parameter RESET_VECTOR, default 32'h0040_0000: PC value loaded on reset.
REQ-003 Parameter TRAP_VECTOR, default 32'h0040_0180: PC value loaded on trap or misaligned redirect.
REQ-004 Parameter STEP, default 4: sequential PC increment.
REQ-005 Parameter ALIGN_BITS, default 2: number of PC LSBs that must be zero in a legal redirect target.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  1 = PC may advance; 0 = stall, PC holds.
REQ-009 redirect_valid  input  1  branch/jump redirect request this cycle.
REQ-010 redirect_target  input  N  redirect destination, sampled when redirect_valid=1.
REQ-011 trap_req  input  1  exception request; overrides stall.
REQ-012 pc_value  output  N  current PC (registered).
REQ-013 pc_prev  output  N  PC value before the most recent change (registered).
REQ-014 epc  output  N  PC captured at the most recent trap or misaligned redirect.
REQ-015 redirect_pending  output  1  a redirect was received during a stall and is held.
REQ-016 misaligned_err  output  1  one-cycle pulse flagging a misaligned redirect.

Function
REQ-017 Priority per edge: reset > trap_req > enable=1 path > enable=0 path.
REQ-018 trap_req=1: pc_value<=TRAP_VECTOR, epc<=pc_value, pc_prev<=pc_value, redirect_pending<=0, regardless of enable.
REQ-019 enable=1, no trap: candidate = redirect_target if redirect_valid=1; else held target if redirect_pending=1; else pc_value+STEP.
REQ-020 Live redirect_valid in the same cycle as a held redirect wins; the held target is discarded.
REQ-021 Redirect candidate (live or held) with any of its ALIGN_BITS LSBs nonzero: pc_value<=TRAP_VECTOR, epc<=pc_value, misaligned_err<=1 for the next cycle only.
REQ-022 Legal candidate: pc_value<=candidate; pc_prev<=pc_value in every enable=1 update; redirect_pending<=0.
REQ-023 Sequential increment is modulo 2^N; pc_value+STEP wraps to low addresses with no error.
REQ-024 enable=0, no trap: pc_value, pc_prev, epc hold; redirect_valid=1 sets redirect_pending<=1 and stores redirect_target, overwriting any older held target (latest wins).
REQ-025 Alignment of a stalled redirect is checked only when it is consumed, not when it is stored.
REQ-026 misaligned_err is 0 in every cycle not immediately following a misaligned consumption.
REQ-027 Latency: every PC change is visible on pc_value exactly one cycle after the sampling edge; no output is combinational from inputs.

Reset
REQ-028 reset=1 at an edge: pc_value<=RESET_VECTOR, pc_prev<=RESET_VECTOR, epc<=0, redirect_pending<=0, held target<=0, misaligned_err<=0.
REQ-029 Reset overrides trap_req, enable and redirect_valid in the same cycle; a pending redirect is lost.
REQ-030 A trap or redirect asserted in the first cycle after reset deasserts is honoured normally.

Verification
REQ-031 Reset, then enable=1 for 3 cycles -> pc_value 0x400000, 0x400004, 0x400008, 0x40000C; pc_prev lags by one.
REQ-032 enable=0, redirect 0x00400100 then 0x00400200 on the next cycle, enable=1 after 2 more cycles -> redirect_pending=1 while stalled, PC then 0x00400200, pending=0.
REQ-033 pc_value=0x00400010, enable=0, trap_req=1 -> pc_value=0x00400180, epc=0x00400010, pending cleared.
REQ-034 enable=1, redirect 0x00400102 -> pc_value=0x00400180, epc=old PC, misaligned_err high exactly one cycle.
REQ-035 N=8, RESET_VECTOR=8'hFC, STEP=4: two enabled cycles -> pc_value 0xFC, 0x00, 0x04; no error flag.
REQ-036 Redirect held, reset=1 with enable=1 and trap_req=1 -> all outputs equal reset values, redirect_pending=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with stall-held redirects, traps and alignment checking
// A redirect that arrives during a stall is parked and checked for alignment only when consumed.
module pc_sequencer #(
  parameter int             N            = 32,
  parameter logic [N-1:0]   RESET_VECTOR = N'(32'h0040_0000),
  parameter logic [N-1:0]   TRAP_VECTOR  = N'(32'h0040_0180),
  parameter int             STEP         = 4,
  parameter int             ALIGN_BITS   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_target,
  input  logic         trap_req,
  output logic [N-1:0] pc_value,
  output logic [N-1:0] pc_prev,
  output logic [N-1:0] epc,
  output logic         redirect_pending,
  output logic         misaligned_err
);

  localparam logic [N-1:0] ALIGN_MASK = N'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [N-1:0] STEP_N     = N'(STEP);

  logic [N-1:0] pc_q,   pc_d;
  logic [N-1:0] prev_q, prev_d;
  logic [N-1:0] epc_q,  epc_d;
  logic [N-1:0] held_q, held_d;
  logic         pend_q, pend_d;
  logic         mis_q,  mis_d;

  logic         use_redirect;
  logic [N-1:0] candidate;
  logic         cand_misaligned;

  // A live redirect always beats a parked one; the sequential step is never alignment-checked.
  assign use_redirect    = redirect_valid | pend_q;
  assign candidate       = redirect_valid ? redirect_target :
                           pend_q         ? held_q          :
                                            pc_q + STEP_N;
  assign cand_misaligned = use_redirect & (|(candidate & ALIGN_MASK));

  always_comb begin
    pc_d   = pc_q;
    prev_d = prev_q;
    epc_d  = epc_q;
    held_d = held_q;
    pend_d = pend_q;
    mis_d  = 1'b0;
    if (trap_req) begin
      pc_d   = TRAP_VECTOR;
      prev_d = pc_q;
      epc_d  = pc_q;
      pend_d = 1'b0;
    end else if (enable) begin
      prev_d = pc_q;
      pend_d = 1'b0;
      if (cand_misaligned) begin
        pc_d  = TRAP_VECTOR;
        epc_d = pc_q;
        mis_d = 1'b1;
      end else begin
        pc_d = candidate;
      end
    end else if (redirect_valid) begin
      pend_d = 1'b1;
      held_d = redirect_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_VECTOR;
      prev_q <= RESET_VECTOR;
      epc_q  <= '0;
      held_q <= '0;
      pend_q <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      prev_q <= prev_d;
      epc_q  <= epc_d;
      held_q <= held_d;
      pend_q <= pend_d;
      mis_q  <= mis_d;
    end
  end

  assign pc_value         = pc_q;
  assign pc_prev          = prev_q;
  assign epc              = epc_q;
  assign redirect_pending = pend_q;
  assign misaligned_err   = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer with directed pins
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0040_0000;
  localparam logic [31:0] TV = 32'h0040_0180;

  logic        clk;
  logic        reset, enable, redirect_valid, trap_req;
  logic [31:0] redirect_target;
  logic [31:0] pc_value, pc_prev, epc;
  logic        redirect_pending, misaligned_err;

  logic        en8;
  logic [7:0]  pc8, prev8, epc8;
  logic        pend8, mis8;

  int total = 0;
  int bad   = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_req(trap_req), .pc_value(pc_value), .pc_prev(pc_prev), .epc(epc),
    .redirect_pending(redirect_pending), .misaligned_err(misaligned_err)
  );

  pc_sequencer #(.N(8), .RESET_VECTOR(8'hFC), .STEP(4)) dut8 (
    .clk(clk), .reset(reset), .enable(en8),
    .redirect_valid(1'b0), .redirect_target(8'h00),
    .trap_req(1'b0), .pc_value(pc8), .pc_prev(prev8), .epc(epc8),
    .redirect_pending(pend8), .misaligned_err(mis8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: architectural state updated from the rules at each rising edge.
  logic [31:0] m_pc, m_prev, m_epc, m_held;
  logic        m_pend, m_mis, m_valid = 1'b0;

  always @(posedge clk) begin
    logic [31:0] cand;
    logic        is_redir, mis_next;
    mis_next = 1'b0;
    if (reset) begin
      m_pc = RV; m_prev = RV; m_epc = 0; m_pend = 0; m_held = 0;
      m_valid = 1'b1;
    end else if (trap_req) begin
      m_prev = m_pc; m_epc = m_pc; m_pc = TV; m_pend = 0;
    end else if (enable) begin
      is_redir = redirect_valid || m_pend;
      if (redirect_valid)  cand = redirect_target;
      else if (m_pend)     cand = m_held;
      else                 cand = m_pc + 32'd4;
      m_prev = m_pc;
      m_pend = 0;
      if (is_redir && (cand % 4) != 0) begin
        m_epc = m_pc; m_pc = TV; mis_next = 1'b1;
      end else begin
        m_pc = cand;
      end
    end else if (redirect_valid) begin
      m_pend = 1; m_held = redirect_target;
    end
    m_mis = mis_next;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_pc",   pc_value, m_pc);
      check("model_prev", pc_prev,  m_prev);
      check("model_epc",  epc,      m_epc);
      check("model_pend", {31'd0, redirect_pending}, {31'd0, m_pend});
      check("model_mis",  {31'd0, misaligned_err},   {31'd0, m_mis});
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1; enable = 0; redirect_valid = 0; trap_req = 0; redirect_target = 0; en8 = 0;
    repeat (2) step();
    check("rst_pc",   pc_value, RV);
    check("rst_prev", pc_prev,  RV);
    check("rst_epc",  epc,      32'h0);
    check("rst_pend", {31'd0, redirect_pending}, 32'd0);
    check("rst_mis",  {31'd0, misaligned_err},   32'd0);
    check("n8_rst",   {24'd0, pc8}, 32'hFC);

    reset = 0; enable = 1; en8 = 1;
    step(); check("seq1_pc", pc_value, 32'h0040_0004); check("seq1_prev", pc_prev, RV);
    check("n8_wrap", {24'd0, pc8}, 32'h00);
    step(); check("seq2_pc", pc_value, 32'h0040_0008); check("seq2_prev", pc_prev, 32'h0040_0004);
    check("n8_pc2", {24'd0, pc8}, 32'h04); check("n8_mis", {31'd0, mis8}, 32'd0);
    en8 = 0;
    step(); check("seq3_pc", pc_value, 32'h0040_000C); check("seq3_prev", pc_prev, 32'h0040_0008);

    enable = 0; redirect_valid = 1; redirect_target = 32'h0040_0100;
    step(); check("stall_pend", {31'd0, redirect_pending}, 32'd1);
    redirect_target = 32'h0040_0200;
    step(); redirect_valid = 0;
    step(); step();
    check("stall_hold_pc", pc_value, 32'h0040_000C);
    check("stall_pend2", {31'd0, redirect_pending}, 32'd1);
    enable = 1;
    step(); check("latest_wins", pc_value, 32'h0040_0200);
    check("consumed_pend", {31'd0, redirect_pending}, 32'd0);
    check("consumed_prev", pc_prev, 32'h0040_000C);

    redirect_valid = 1; redirect_target = 32'h0040_0010;
    step(); check("redir_pc", pc_value, 32'h0040_0010);
    enable = 0; redirect_target = 32'h0040_0300;
    step(); redirect_valid = 0; trap_req = 1;
    step(); check("trap_pc", pc_value, TV); check("trap_epc", epc, 32'h0040_0010);
    check("trap_pend", {31'd0, redirect_pending}, 32'd0);
    trap_req = 0; enable = 1;
    step(); check("after_trap_pc", pc_value, 32'h0040_0184);
    redirect_valid = 1; redirect_target = 32'h0040_0102;
    step(); check("mis_pc", pc_value, TV); check("mis_epc", epc, 32'h0040_0184);
    check("mis_pulse", {31'd0, misaligned_err}, 32'd1);
    redirect_valid = 0; enable = 0;
    step(); check("mis_drop", {31'd0, misaligned_err}, 32'd0);

    redirect_valid = 1; redirect_target = 32'h0040_0400;
    step(); enable = 1; redirect_target = 32'h0040_0500;
    step(); check("live_beats_held", pc_value, 32'h0040_0500);
    redirect_valid = 0;
    step(); check("held_discarded", pc_value, 32'h0040_0504);

    enable = 0; redirect_valid = 1; redirect_target = 32'h0040_0401;
    step(); check("store_no_mis", {31'd0, misaligned_err}, 32'd0);
    redirect_valid = 0; enable = 1;
    step(); check("held_mis_pc", pc_value, TV); check("held_mis_epc", epc, 32'h0040_0504);
    check("held_mis_pulse", {31'd0, misaligned_err}, 32'd1);

    enable = 0; redirect_valid = 1; redirect_target = 32'h0040_0600;
    step(); reset = 1; enable = 1; trap_req = 1;
    step(); check("rst_ovr_pc", pc_value, RV); check("rst_ovr_epc", epc, 32'h0);
    check("rst_ovr_pend", {31'd0, redirect_pending}, 32'd0);
    reset = 0; enable = 0; redirect_valid = 0;
    step(); check("post_rst_trap", pc_value, TV); check("post_rst_epc", epc, RV);
    trap_req = 0;

    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 199) == 0);
      trap_req       = ($urandom_range(0, 19) == 0);
      enable         = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 9) == 0) redirect_target = 32'hFFFF_FFF8;
      else redirect_target = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) redirect_target = redirect_target | 32'($urandom_range(1, 3));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
